arm_multicycle_ctrl: RTL and testbench

//  Multicycle main controller for the ARM core. It sequences a shared-ALU, single-memory datapath through FETCH..WRITEBACK states.

---
 rtl/arm_ctrl_pkg.sv | 77 +++++++
 rtl/arm_multicycle_ctrl_cond.sv | 42 ++++
 rtl/arm_multicycle_ctrl.sv | 157 +++++++++++++++
 tb/tb_arm_multicycle_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, mux selects,
// ALU operations and condition codes, plus the ARM condition evaluator.
package arm_ctrl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Flags are ordered {N,Z,C,V}; code 1111 never executes.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: cond_eval = z;
            COND_NE: cond_eval = !z;
            COND_CS: cond_eval = c;
            COND_CC: cond_eval = !c;
            COND_MI: cond_eval = n;
            COND_PL: cond_eval = !n;
            COND_VS: cond_eval = v;
            COND_VC: cond_eval = !v;
            COND_HI: cond_eval = c && !z;
            COND_LS: cond_eval = !c || z;
            COND_GE: cond_eval = (n == v);
            COND_LT: cond_eval = (n != v);
            COND_GT: cond_eval = !z && (n == v);
            COND_LE: cond_eval = z || (n != v);
            COND_AL: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arm_multicycle_ctrl_cond.sv
// NZCV flag register and condition-pass latch for the multicycle controller.
module arm_cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_w_i,
    input  logic       latch_en_i,
    output logic       cond_ex_o,
    output logic       cond_ex_q_o,
    output logic [3:0] flags_o
);

    logic [3:0] flags_q, flags_d;
    logic       cond_ex_q, cond_ex_d;

    // flag_w_i[1] updates N,Z; flag_w_i[0] updates C,V so logical ops keep carry/overflow.
    always_comb begin
        cond_ex_o = cond_eval(cond_i, flags_q);
        flags_d   = flags_q;
        cond_ex_d = cond_ex_q;
        if (flag_w_i[1]) flags_d[3:2] = alu_flags_i[3:2];
        if (flag_w_i[0]) flags_d[1:0] = alu_flags_i[1:0];
        if (latch_en_i)  cond_ex_d = cond_ex_o;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    assign cond_ex_q_o = cond_ex_q;
    assign flags_o     = flags_q;

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM main controller: FSM, datapath control decode and condition gating.
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr,
    input  logic [3:0]         alu_flags,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_control,
    output logic [1:0]         imm_src,
    output logic [1:0]         reg_src,
    output logic               illegal,
    output logic [STATE_W-1:0] state_o
);

    state_t     state_q, state_d;
    logic [1:0] op;
    logic [5:0] funct;
    logic       rd_is_pc;
    logic       cmd_ok;
    logic [1:0] dp_alu;
    logic [1:0] flag_w;
    logic       cond_ex, cond_ex_q;
    logic [3:0] flags_unused;

    assign op       = instr[27:26];
    assign funct    = instr[25:20];
    assign rd_is_pc = (instr[15:12] == 4'hF);
    assign imm_src  = op;
    assign reg_src  = {op == OP_MEM, op == OP_BR};
    assign state_o  = STATE_W'(state_q);

    always_comb begin
        cmd_ok = 1'b1;
        case (funct[4:1])
            4'b0100: dp_alu = ALU_ADD;
            4'b0010: dp_alu = ALU_SUB;
            4'b0000: dp_alu = ALU_AND;
            4'b1100: dp_alu = ALU_ORR;
            default: begin
                dp_alu = ALU_ADD;
                cmd_ok = 1'b0;
            end
        endcase
    end

    arm_cond_unit u_cond (
        .clk         (clk),
        .reset       (reset),
        .cond_i      (instr[31:28]),
        .alu_flags_i (alu_flags),
        .flag_w_i    (flag_w),
        .latch_en_i  (state_q == DECODE),
        .cond_ex_o   (cond_ex),
        .cond_ex_q_o (cond_ex_q),
        .flags_o     (flags_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Architectural writes are gated by the condition latched in DECODE; the
    // fetch-side PC/IR loads are not, and reset suppresses every write.
    always_comb begin
        state_d     = FETCH;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_RD2;
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        flag_w      = 2'b00;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                state_d    = DECODE;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                case (op)
                    OP_DP: begin
                        if (!cmd_ok) illegal = 1'b1;
                        else         state_d = funct[5] ? EXECI : EXECR;
                    end
                    OP_MEM:  state_d = MEMADR;
                    OP_BR:   state_d = BRANCH;
                    default: illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_b = SRCB_IMM;
                state_d   = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = cond_ex_q;
                pc_write   = cond_ex_q && rd_is_pc;
            end
            MEMWR: begin
                adr_src   = 1'b1;
                mem_write = cond_ex_q;
            end
            EXECR, EXECI: begin
                alu_src_b   = (state_q == EXECI) ? SRCB_IMM : SRCB_RD2;
                alu_control = dp_alu;
                if (funct[0] && cond_ex_q)
                    flag_w = (dp_alu == ALU_ADD || dp_alu == ALU_SUB) ? 2'b11 : 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = cond_ex_q;
                pc_write   = cond_ex_q && rd_is_pc;
            end
            BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURES;
                pc_write   = cond_ex_q;
            end
            default: state_d = FETCH;
        endcase
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
            flag_w    = 2'b00;
        end
    end

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Scoreboard bench for arm_multicycle_ctrl: per-cycle expected control words are
// queued when an instruction is presented and popped as the FSM walks through it.
module tb_arm_multicycle_ctrl;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXECR  = 4'd6;
    localparam logic [3:0] ST_EXECI  = 4'd7;
    localparam logic [3:0] ST_ALUWB  = 4'd8;
    localparam logic [3:0] ST_BRANCH = 4'd9;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a, illegal;
    logic [1:0]  result_src, alu_src_b, alu_control, imm_src, reg_src;
    logic [3:0]  state_o;
    logic [20:0] obsVec;

    int          checks = 0;
    int          errors = 0;
    logic [20:0] sbQueue[$];
    logic [3:0]  modelFlags;

    arm_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .alu_flags   (alu_flags),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .imm_src     (imm_src),
        .reg_src     (reg_src),
        .illegal     (illegal),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    assign obsVec = {state_o, pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                     alu_src_a, alu_src_b, alu_control, imm_src, reg_src, illegal};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic condModel(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy & !z;
            4'h9: return !cy | z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z & (n == v);
            4'hD: return z | (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Returns {legal, aluCode} for the DP command field.
    function automatic logic [2:0] dpModel(input logic [31:0] ins);
        case (ins[24:21])
            4'b0100: return 3'b100;
            4'b0010: return 3'b101;
            4'b0000: return 3'b110;
            4'b1100: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [20:0] expVec(input logic [3:0] st, input logic [31:0] ins,
                                           input logic ok, input logic rst);
        logic       pcw, adr, memw, irw, regw, srcA, ill, rdPc;
        logic [1:0] res, srcB, aluc, op;
        logic [2:0] dp;
        op = ins[27:26];
        dp = dpModel(ins);
        rdPc = (ins[15:12] == 4'hF);
        {pcw, adr, memw, irw, regw, srcA, ill} = 7'b0;
        res = 2'b00; srcB = 2'b00; aluc = 2'b00;
        case (st)
            ST_FETCH:  begin irw = 1; pcw = 1; srcA = 1; srcB = 2'b10; res = 2'b10; end
            ST_DECODE: begin
                srcA = 1; srcB = 2'b10; res = 2'b10;
                ill = (op == 2'b11) || (op == 2'b00 && !dp[2]);
            end
            ST_MEMADR: srcB = 2'b01;
            ST_MEMRD:  adr = 1;
            ST_MEMWB:  begin res = 2'b01; regw = ok; pcw = ok & rdPc; end
            ST_MEMWR:  begin adr = 1; memw = ok; end
            ST_EXECR:  aluc = dp[1:0];
            ST_EXECI:  begin srcB = 2'b01; aluc = dp[1:0]; end
            ST_ALUWB:  begin regw = ok; pcw = ok & rdPc; end
            ST_BRANCH: begin srcB = 2'b01; res = 2'b10; pcw = ok; end
            default: ;
        endcase
        if (rst) {pcw, irw, regw, memw} = 4'b0;
        return {st, pcw, adr, memw, irw, regw, res, srcA, srcB, aluc, op,
                op == 2'b01, op == 2'b10, ill};
    endfunction

    // Called at a falling edge with the DUT in FETCH; returns at the falling edge
    // of the next FETCH, or right after cycle abortAfter when abortAfter > 0.
    task automatic applyStimulus(input logic [31:0] ins, input logic [3:0] fl, input int abortAfter);
        logic        ok;
        logic [2:0]  dp;
        logic [3:0]  seq[$];
        logic [20:0] e;
        int          n;
        instr     = ins;
        alu_flags = fl;
        ok = condModel(ins[31:28], modelFlags);
        dp = dpModel(ins);
        seq.push_back(ST_FETCH);
        seq.push_back(ST_DECODE);
        case (ins[27:26])
            2'b00: if (dp[2]) begin
                seq.push_back(ins[25] ? ST_EXECI : ST_EXECR);
                seq.push_back(ST_ALUWB);
            end
            2'b01: begin
                seq.push_back(ST_MEMADR);
                if (ins[20]) begin seq.push_back(ST_MEMRD); seq.push_back(ST_MEMWB); end
                else seq.push_back(ST_MEMWR);
            end
            2'b10: seq.push_back(ST_BRANCH);
            default: ;
        endcase
        foreach (seq[i]) sbQueue.push_back(expVec(seq[i], ins, ok, 1'b0));
        n = 0;
        while (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            #1;
            checkOutput($sformatf("%h.cyc%0d", ins, n), {11'b0, obsVec}, {11'b0, e});
            if ((e[20:17] == ST_EXECR || e[20:17] == ST_EXECI) && ins[20] && ok) begin
                modelFlags[3:2] = fl[3:2];
                if (dp[1] == 1'b0) modelFlags[1:0] = fl[1:0];
            end
            n++;
            if (abortAfter > 0 && n == abortAfter) sbQueue.delete();
            else @(negedge clk);
        end
        checkOutput($sformatf("%h.flags", ins), {28'b0, dut.u_cond.flags_q}, {28'b0, modelFlags});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        instr      = 32'hE2821005;
        alu_flags  = 4'b0000;
        modelFlags = 4'b0000;
        @(negedge clk);
        #1;
        checkOutput("resetVec", {11'b0, obsVec}, {11'b0, expVec(ST_FETCH, instr, 1'b0, 1'b1)});
        checkOutput("resetFlags", {28'b0, dut.u_cond.flags_q}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(32'hE2821005, 4'b1111, 0);   // ADD R1,R2,#5 (no S)
        applyStimulus(32'hE0500000, 4'b0100, 0);   // SUBS R0,R0,R0 -> Z
        applyStimulus(32'h02821005, 4'b0000, 0);   // ADDEQ executes
        applyStimulus(32'h12821005, 4'b0000, 0);   // ADDNE suppressed
        applyStimulus(32'hE5943008, 4'b0000, 0);   // LDR R3,[R4,#8]
        applyStimulus(32'hE5843008, 4'b0000, 0);   // STR R3,[R4,#8]
        applyStimulus(32'h1A000002, 4'b0000, 0);   // BNE, Z=1: not taken
        applyStimulus(32'hE2921005, 4'b0000, 0);   // ADDS clears flags
        applyStimulus(32'h1A000002, 4'b0000, 0);   // BNE, Z=0: taken
        applyStimulus(32'hE0111002, 4'b1011, 0);   // ANDS: NZ=10, CV held
        applyStimulus(32'hE080F001, 4'b0000, 0);   // ADD PC,R0,R1
        applyStimulus(32'hE1811002, 4'b0000, 0);   // ORR R1,R1,R2
        applyStimulus(32'hF2821005, 4'b0000, 0);   // cond 1111: never
        applyStimulus(32'hE0200000, 4'b0000, 0);   // EOR: illegal
        applyStimulus(32'hE5943008, 4'b0000, 0);   // LDR after illegal
        applyStimulus(32'hE0500000, 4'b0100, 0);   // SUBS -> flags 0100

        applyStimulus(32'hE5843008, 4'b0000, 4);   // STR, stop in MEMWR
        reset = 1'b1;
        #1;
        checkOutput("rstMidVec", {11'b0, obsVec}, {11'b0, expVec(ST_FETCH, instr, 1'b0, 1'b1)});
        checkOutput("rstMidFlags", {28'b0, dut.u_cond.flags_q}, 32'h0);
        checkOutput("rstMidCond", {31'b0, dut.u_cond.cond_ex_q}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        modelFlags = 4'b0000;
        applyStimulus(32'hE2821005, 4'b0000, 0);   // resumes cleanly after reset

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
